// File: rtl/dual_cam_rd_sched.sv
// dual_cam_rd_sched: shares the LCD pixel stream between two camera line FIFOs (left half / right half)
// Ports: lcd_clk/sys_rst_n clock and async active-low reset; enable, data_req, pixel_xpos/ypos, rd_h/v_pixel request side;
// fifoN_rdy/empty/dout FIFO status and data in, fifoN_rd_en read strobes out; rd_data pixel out; active, frame_start, ufN_cnt status.
module dual_cam_rd_sched #(
  parameter logic [23:0] BLACK = 24'h000000,
  parameter int CNT_W = 16
) (
  input  logic             lcd_clk,
  input  logic             sys_rst_n,
  input  logic             enable,
  input  logic             data_req,
  input  logic [10:0]      pixel_xpos,
  input  logic [10:0]      pixel_ypos,
  input  logic [12:0]      rd_h_pixel,
  input  logic [12:0]      rd_v_pixel,
  input  logic             fifo0_rdy,
  input  logic             fifo1_rdy,
  input  logic             fifo0_empty,
  input  logic             fifo1_empty,
  input  logic [23:0]      fifo0_dout,
  input  logic [23:0]      fifo1_dout,
  output logic             fifo0_rd_en,
  output logic             fifo1_rd_en,
  output logic [23:0]      rd_data,
  output logic             active,
  output logic             frame_start,
  output logic [CNT_W-1:0] uf0_cnt,
  output logic [CNT_W-1:0] uf1_cnt
);
  typedef enum logic [1:0] {IDLE, FILL, ACTIVE} state_t;
  state_t state_q, state_d;
  logic resync_q, resync_d, hit_q, hit_d, sel_q, sel_d, fs_q;
  logic [CNT_W-1:0] uf0_q, uf0_d, uf1_q, uf1_d;
  logic [12:0] half, xpos;
  logic fs, in_frame, sel, leave, serve, uf0, uf1;
  assign half = {1'b0, rd_h_pixel[12:1]};
  assign xpos = {2'b00, pixel_xpos};
  assign in_frame = ({2'b00, pixel_ypos} < rd_v_pixel) && (xpos < rd_h_pixel);
  assign sel = xpos >= half;
  assign fs = data_req && pixel_xpos == '0 && pixel_ypos == '0;
  // An FS that ends the ACTIVE period is not served, so the new frame starts cleanly in FILL/IDLE
  assign leave = fs && (resync_q || !enable);
  assign serve = state_q == ACTIVE && data_req && in_frame && !leave;
  assign fifo0_rd_en = serve && !sel && !fifo0_empty;
  assign fifo1_rd_en = serve && sel && !fifo1_empty;
  assign uf0 = serve && !sel && fifo0_empty;
  assign uf1 = serve && sel && fifo1_empty;
  always_comb begin
    state_d = state_q;
    if (state_q == IDLE) state_d = enable ? FILL : IDLE;
    else if (fs && !enable) state_d = IDLE;
    else if (state_q == FILL && fs && fifo0_rdy && fifo1_rdy) state_d = ACTIVE;
    else if (state_q == ACTIVE && leave) state_d = FILL;
  end
  assign resync_d = (state_q == ACTIVE && leave) ? 1'b0 : (resync_q || uf0 || uf1);
  assign uf0_d = (uf0 && ~&uf0_q) ? uf0_q + CNT_W'(1) : uf0_q;
  assign uf1_d = (uf1 && ~&uf1_q) ? uf1_q + CNT_W'(1) : uf1_q;
  assign hit_d = fifo0_rd_en || fifo1_rd_en;
  assign sel_d = sel;
  always_ff @(posedge lcd_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q  <= IDLE;
      resync_q <= 1'b0;
      hit_q    <= 1'b0;
      sel_q    <= 1'b0;
      fs_q     <= 1'b0;
      uf0_q    <= '0;
      uf1_q    <= '0;
    end else begin
      state_q  <= state_d;
      resync_q <= resync_d;
      hit_q    <= hit_d;
      sel_q    <= sel_d;
      fs_q     <= fs;
      uf0_q    <= uf0_d;
      uf1_q    <= uf1_d;
    end
  end
  // FIFO data is already one cycle behind its read strobe, so the mux alone gives 1-cycle latency
  assign rd_data = hit_q ? (sel_q ? fifo1_dout : fifo0_dout) : BLACK;
  assign active = state_q == ACTIVE;
  assign frame_start = fs_q;
  assign uf0_cnt = uf0_q;
  assign uf1_cnt = uf1_q;
endmodule

// File: tb/tb_dual_cam_rd_sched.sv
// tb_dual_cam_rd_sched: scoreboard bench for dual_cam_rd_sched
module tb_dual_cam_rd_sched;
  logic lcd_clk = 1'b0, sys_rst_n = 1'b0, enable = 1'b0, data_req = 1'b0;
  logic [10:0] px = '0, py = '0;
  logic [12:0] hp = 13'd1280, vp = 13'd720;
  logic r0 = 1'b1, r1 = 1'b1, e0 = 1'b0, e1 = 1'b0;
  logic [23:0] d0 = '0, d1 = '0;
  logic fifo0_rd_en, fifo1_rd_en, active, frame_start;
  logic [23:0] rd_data;
  logic [15:0] uf0_cnt, uf1_cnt;
  dual_cam_rd_sched dut (
    .lcd_clk(lcd_clk), .sys_rst_n(sys_rst_n), .enable(enable), .data_req(data_req),
    .pixel_xpos(px), .pixel_ypos(py), .rd_h_pixel(hp), .rd_v_pixel(vp),
    .fifo0_rdy(r0), .fifo1_rdy(r1), .fifo0_empty(e0), .fifo1_empty(e1),
    .fifo0_dout(d0), .fifo1_dout(d1), .fifo0_rd_en(fifo0_rd_en), .fifo1_rd_en(fifo1_rd_en),
    .rd_data(rd_data), .active(active), .frame_start(frame_start),
    .uf0_cnt(uf0_cnt), .uf1_cnt(uf1_cnt)
  );
  always #5 lcd_clk = ~lcd_clk;
  typedef struct packed {logic en0; logic en1; logic [23:0] d;} exp_t;
  exp_t q[$];
  int checks = 0, failures = 0;
  int c0 = 0, c1 = 0, n0 = 0, n1 = 0, cnt0 = 0, cnt1 = 0;
  logic mon_on = 1'b0;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s got=%h exp=%h at %0t", name, act, req, $time);
    end
  endtask
  always @(posedge lcd_clk) begin
    if (fifo0_rd_en) begin
      d0 <= {8'h10, c0[15:0]};
      c0 <= c0 + 1;
    end
    if (fifo1_rd_en) begin
      d1 <= {8'h20, c1[15:0]};
      c1 <= c1 + 1;
    end
  end
  initial begin
    exp_t e;
    logic [23:0] pend;
    pend = 24'h0;
    forever begin
      @(negedge lcd_clk);
      if (mon_on && q.size() > 0) begin
        e = q.pop_front();
        chk("rd_en0", fifo0_rd_en, e.en0);
        chk("rd_en1", fifo1_rd_en, e.en1);
        chk("rd_data", rd_data, pend);
        pend = e.d;
        cnt0 += fifo0_rd_en ? 1 : 0;
        cnt1 += fifo1_rd_en ? 1 : 0;
      end
    end
  end
  task automatic cyc(input logic r, input int x, input int y, input int k);
    exp_t e;
    @(posedge lcd_clk);
    #1;
    data_req = r;
    px = x[10:0];
    py = y[10:0];
    e = '0;
    if (k == 1) begin
      e = {1'b1, 1'b0, 8'h10, n0[15:0]};
      n0++;
    end else if (k == 2) begin
      e = {1'b0, 1'b1, 8'h20, n1[15:0]};
      n1++;
    end
    q.push_back(e);
  endtask
  initial begin
    int s0, s1;
    #12;
    chk("rst_rd_data", rd_data, 24'h0);
    chk("rst_active", active, 0);
    chk("rst_frame_start", frame_start, 0);
    chk("rst_uf0", uf0_cnt, 0);
    chk("rst_uf1", uf1_cnt, 0);
    chk("rst_rd_en", {fifo0_rd_en, fifo1_rd_en}, 0);
    @(posedge lcd_clk);
    #1;
    sys_rst_n = 1'b1;
    enable = 1'b1;
    mon_on = 1'b1;
    cyc(0, 0, 0, 0);
    cyc(1, 0, 0, 0);
    s0 = cnt0;
    s1 = cnt1;
    for (int x = 1; x < 1280; x++) begin
      cyc(1, x, 0, x < 640 ? 1 : 2);
      if (x == 1) begin
        chk("active_after_fs", active, 1);
        chk("frame_start_pulse", frame_start, 1);
      end
      if (x == 2) chk("frame_start_single", frame_start, 0);
    end
    cyc(0, 0, 0, 0);
    chk("line0_rd0_count", cnt0 - s0, 639);
    chk("line0_rd1_count", cnt1 - s1, 640);
    s0 = cnt0;
    s1 = cnt1;
    for (int x = 0; x < 1280; x++) cyc(1, x, 1, x < 640 ? 1 : 2);
    cyc(0, 0, 0, 0);
    chk("line1_rd0_count", cnt0 - s0, 640);
    chk("line1_rd1_count", cnt1 - s1, 640);
    cyc(1, 639, 2, 1);
    cyc(1, 640, 2, 2);
    cyc(0, 0, 0, 0);
    e1 = 1'b1;
    for (int i = 0; i < 3; i++) cyc(1, 700 + i, 3, 0);
    cyc(0, 0, 0, 0);
    e1 = 1'b0;
    chk("uf1_count", uf1_cnt, 3);
    chk("active_before_resync", active, 1);
    cyc(1, 0, 0, 0);
    cyc(0, 0, 0, 0);
    chk("resync_to_fill", active, 0);
    chk("frame_start_in_active", frame_start, 1);
    cyc(1, 0, 0, 0);
    cyc(1, 1, 0, 1);
    chk("reactivate", active, 1);
    chk("frame_start_in_fill", frame_start, 1);
    cyc(0, 0, 0, 0);
    e0 = 1'b1;
    repeat (65534) cyc(1, 5, 1, 0);
    cyc(0, 0, 0, 0);
    chk("uf0_preload", uf0_cnt, 16'hFFFE);
    repeat (3) cyc(1, 5, 1, 0);
    cyc(0, 0, 0, 0);
    chk("uf0_saturate", uf0_cnt, 16'hFFFF);
    e0 = 1'b0;
    vp = 13'd480;
    cyc(1, 10, 500, 0);
    cyc(1, 1300, 10, 0);
    cyc(1, 2, 10, 1);
    cyc(0, 0, 0, 0);
    @(negedge lcd_clk);
    #1;
    chk("scoreboard_drained", q.size(), 0);
    mon_on = 1'b0;
    @(posedge lcd_clk);
    #1;
    data_req = 1'b1;
    px = 11'd3;
    py = 11'd10;
    #1;
    chk("pre_rst_rd_en0", fifo0_rd_en, 1);
    @(posedge lcd_clk);
    #1;
    px = 11'd4;
    #1;
    chk("pre_rst_rd_data", rd_data, {8'h10, n0[15:0]});
    chk("pre_rst_rd_en0_b", fifo0_rd_en, 1);
    sys_rst_n = 1'b0;
    #1;
    chk("arst_rd_en", {fifo0_rd_en, fifo1_rd_en}, 0);
    chk("arst_rd_data", rd_data, 24'h0);
    chk("arst_active", active, 0);
    chk("arst_uf0", uf0_cnt, 0);
    chk("arst_uf1", uf1_cnt, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
